// File: rtl/team_06_lcd_pkg.sv
// Shared types, HD44780 command codes and PCF8574 expander bit layout for the LCD sequencer.
package team_06_lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_CLEAR,
    ST_ADDR,
    ST_CHARS,
    ST_GAP,
    ST_RETRY_WAIT,
    ST_FAULT,
    ST_BL_OFF
  } lcd_state_t;

  typedef enum logic [2:0] {
    TX_LOAD,
    TX_WAIT_IDLE,
    TX_XFER,
    TX_POST,
    TX_GAP,
    TX_ADV
  } tx_step_t;

  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h28;
  localparam logic [7:0] LCD_CMD_INIT_32    = 8'h32;
  localparam logic [7:0] LCD_CMD_INIT_33    = 8'h33;
  localparam logic [7:0] LCD_CMD_SET_ADDR   = 8'h80;

  localparam int EXP_BL = 3;
  localparam int EXP_E  = 2;
  localparam int EXP_RW = 1;
  localparam int EXP_RS = 0;

  localparam int INIT_LEN = 5;

  // 0x33/0x32 pair forces the controller into 4-bit mode from any nibble phase.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return LCD_CMD_INIT_33;
      3'd1:    return LCD_CMD_INIT_32;
      3'd2:    return LCD_CMD_FUNC_SET;
      3'd3:    return LCD_CMD_DISPLAY_ON;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input logic [3:0] nib, input logic bl,
                                          input logic e, input logic rs);
    logic [7:0] b;
    b = {nib, 4'b0000};
    b[EXP_BL] = bl;
    b[EXP_E]  = e;
    b[EXP_RW] = 1'b0;
    b[EXP_RS] = rs;
    return b;
  endfunction

endpackage

// File: rtl/team_06_lcd_msg_rom.sv
// Fixed message table: (msg, idx) -> ASCII byte; unused positions and out-of-range messages read 0x00.
module team_06_lcd_msg_rom #(
  parameter int NUM_MSGS = 8,
  parameter int MSG_W    = 3,
  parameter int IDX_W    = 5
) (
  input  logic [MSG_W-1:0] msg,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       ch
);

  localparam int ROM_CHARS = 16;

  logic [8*ROM_CHARS-1:0] line;
  logic [8*ROM_CHARS-1:0] shifted;

  // Messages are stored left-justified so character 0 sits in the top byte.
  always_comb begin
    line = '0;
    if (int'(msg) < NUM_MSGS) begin
      case (int'(msg))
        0:       line = {"HELLO", 88'h0};
        1:       line = {"ECHO", 96'h0};
        2:       line = {"TEAM 06", 72'h0};
        3:       line = {"READY", 88'h0};
        4:       line = {"FAULT", 88'h0};
        5:       line = "0123456789ABCDEF";
        6:       line = {"LCD", 104'h0};
        7:       line = {"BYE", 104'h0};
        default: line = '0;
      endcase
    end
    shifted = line << (8 * int'(idx));
    ch = (int'(idx) < ROM_CHARS) ? shifted[8*ROM_CHARS-1 -: 8] : 8'h00;
  end

endmodule

// File: rtl/team_06_lcd_sequencer.sv
// HD44780 4-bit sequencer over a PCF8574 I2C backpack: power-up init, message redraw, retry and fault.
// Optional LCD_BACKLIGHT_TIMEOUT_EN adds an idle backlight-off timer (parameter BL_TIMEOUT).
module team_06_lcd_sequencer
  import team_06_lcd_pkg::*;
#(
  parameter int MAX_CHARS  = 16,
  parameter int NUM_MSGS   = 8,
  parameter int MSG_W      = 3,
  parameter int PWRUP_WAIT = 400000,
  parameter int CMD_GAP    = 20000,
  parameter int MAX_RETRY  = 3
`ifdef LCD_BACKLIGHT_TIMEOUT_EN
  , parameter int BL_TIMEOUT = 100000000
`endif
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [MSG_W-1:0] msg_sel,
  input  logic             i2c_idle,
  input  logic             i2c_ready,
  input  logic             i2c_err,
  output logic             i2c_start,
  output logic [7:0]       i2c_byte,
  output logic             i2c_last,
  output logic             busy,
  output logic [MSG_W-1:0] shown_msg,
  output logic             shown_valid,
  output logic             lcd_fault,
  output lcd_state_t       dbg_state
);

  localparam int WAIT_MAX = (PWRUP_WAIT > CMD_GAP) ? PWRUP_WAIT : CMD_GAP;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int IDX_W    = $clog2(MAX_CHARS + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRY + 2);

  lcd_state_t         state;
  tx_step_t           step;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [2:0]         init_idx;
  logic [IDX_W-1:0]   char_idx;
  logic [RETRY_W-1:0] retry_cnt;
  logic [MSG_W-1:0]   cur_msg;
  logic [MSG_W-1:0]   fault_msg;
  logic [7:0]         cur_byte;
  logic               cur_rs;
  logic [1:0]         nib_cnt;
  logic [7:0]         rom_ch;
  logic [7:0]         sel_byte;
  logic               sel_rs;
  logic               bl;
  logic               strobe;

`ifdef LCD_BACKLIGHT_TIMEOUT_EN
  localparam int BL_W = $clog2(BL_TIMEOUT + 1);
  logic [BL_W-1:0] idle_cnt;
  logic            bl_q;
  assign bl = bl_q;
`else
  assign bl = 1'b1;
`endif

  assign dbg_state = state;
  // The backlight-off transaction must not clock the controller.
  assign strobe = (state != ST_BL_OFF);

  team_06_lcd_msg_rom #(
    .NUM_MSGS (NUM_MSGS),
    .MSG_W    (MSG_W),
    .IDX_W    (IDX_W)
  ) u_rom (
    .msg (cur_msg),
    .idx (char_idx),
    .ch  (rom_ch)
  );

  always_comb begin
    sel_byte = 8'h00;
    sel_rs   = 1'b0;
    case (state)
      ST_INIT:  sel_byte = init_cmd(init_idx);
      ST_CLEAR: sel_byte = LCD_CMD_CLEAR;
      ST_ADDR:  sel_byte = LCD_CMD_SET_ADDR;
      ST_CHARS: begin
        sel_byte = rom_ch;
        sel_rs   = 1'b1;
      end
      default:  sel_byte = 8'h00;
    endcase
  end

  // I2C handshake: i2c_start pulses only while i2c_idle with byte 0 already on i2c_byte;
  // each byte is held until its i2c_ready pulse, and the 4th ready closes the transaction.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_PWRUP;
      step        <= TX_LOAD;
      wait_cnt    <= '0;
      init_idx    <= '0;
      char_idx    <= '0;
      retry_cnt   <= '0;
      cur_msg     <= '0;
      fault_msg   <= '0;
      cur_byte    <= '0;
      cur_rs      <= 1'b0;
      nib_cnt     <= '0;
      i2c_start   <= 1'b0;
      i2c_byte    <= 8'h08;
      i2c_last    <= 1'b0;
      busy        <= 1'b1;
      shown_msg   <= '0;
      shown_valid <= 1'b0;
      lcd_fault   <= 1'b0;
`ifdef LCD_BACKLIGHT_TIMEOUT_EN
      idle_cnt    <= '0;
      bl_q        <= 1'b1;
`endif
    end else begin
      i2c_start <= 1'b0;
      if (step == TX_XFER && i2c_err) begin
        shown_valid <= 1'b0;
        retry_cnt   <= retry_cnt + 1'b1;
        i2c_last    <= 1'b0;
        i2c_byte    <= exp_byte(4'h0, bl, 1'b0, 1'b0);
        step        <= TX_LOAD;
        wait_cnt    <= '0;
        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          state <= ST_RETRY_WAIT;
        end else begin
          state     <= ST_FAULT;
          lcd_fault <= 1'b1;
          busy      <= 1'b0;
          fault_msg <= msg_sel;
        end
      end else begin
        case (state)
          ST_PWRUP: begin
            if (wait_cnt == WAIT_W'(PWRUP_WAIT - 1)) begin
              state    <= ST_INIT;
              init_idx <= '0;
              step     <= TX_LOAD;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            if (!shown_valid || msg_sel != shown_msg) begin
              cur_msg <= msg_sel;
              state   <= ST_CLEAR;
              step    <= TX_LOAD;
              busy    <= 1'b1;
`ifdef LCD_BACKLIGHT_TIMEOUT_EN
              bl_q     <= 1'b1;
              idle_cnt <= '0;
            end else if (bl_q && idle_cnt == BL_W'(BL_TIMEOUT - 1)) begin
              state    <= ST_BL_OFF;
              bl_q     <= 1'b0;
              step     <= TX_LOAD;
              busy     <= 1'b1;
              idle_cnt <= '0;
            end else if (bl_q) begin
              idle_cnt <= idle_cnt + 1'b1;
`endif
            end
          end
          ST_GAP: begin
            shown_msg   <= cur_msg;
            shown_valid <= 1'b1;
            retry_cnt   <= '0;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end
          ST_RETRY_WAIT: begin
            if (wait_cnt == WAIT_W'(CMD_GAP - 1)) begin
              state    <= ST_INIT;
              init_idx <= '0;
              step     <= TX_LOAD;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_FAULT: begin
            if (msg_sel != fault_msg) begin
              lcd_fault <= 1'b0;
              retry_cnt <= '0;
              state     <= ST_INIT;
              init_idx  <= '0;
              step      <= TX_LOAD;
              busy      <= 1'b1;
            end
          end
          default: begin
            case (step)
              TX_LOAD: begin
                if (state == ST_CHARS && rom_ch == 8'h00) begin
                  state <= ST_GAP;
                end else begin
                  cur_byte <= sel_byte;
                  cur_rs   <= sel_rs;
                  i2c_byte <= exp_byte(sel_byte[7:4], bl, strobe, sel_rs);
                  step     <= TX_WAIT_IDLE;
                end
              end
              TX_WAIT_IDLE: begin
                if (i2c_idle) begin
                  i2c_start <= 1'b1;
                  nib_cnt   <= '0;
                  step      <= TX_XFER;
                end
              end
              TX_XFER: begin
                if (i2c_ready) begin
                  nib_cnt <= nib_cnt + 2'd1;
                  case (nib_cnt)
                    2'd0: i2c_byte <= exp_byte(cur_byte[7:4], bl, 1'b0, cur_rs);
                    2'd1: i2c_byte <= exp_byte(cur_byte[3:0], bl, strobe, cur_rs);
                    2'd2: begin
                      i2c_byte <= exp_byte(cur_byte[3:0], bl, 1'b0, cur_rs);
                      i2c_last <= 1'b1;
                    end
                    default: begin
                      i2c_last <= 1'b0;
                      step     <= TX_POST;
                    end
                  endcase
                end
              end
              TX_POST: begin
                if (i2c_idle) begin
                  if (state == ST_INIT || state == ST_CLEAR) begin
                    step     <= TX_GAP;
                    wait_cnt <= '0;
                  end else begin
                    step <= TX_ADV;
                  end
                end
              end
              TX_GAP: begin
                if (wait_cnt == WAIT_W'(CMD_GAP - 1)) begin
                  step <= TX_ADV;
                end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                end
              end
              TX_ADV: begin
                step <= TX_LOAD;
                case (state)
                  ST_INIT: begin
                    if (init_idx == 3'(INIT_LEN - 1)) begin
                      state <= ST_IDLE;
                      busy  <= 1'b0;
                    end else begin
                      init_idx <= init_idx + 3'd1;
                    end
                  end
                  ST_CLEAR: state <= ST_ADDR;
                  ST_ADDR: begin
                    state    <= ST_CHARS;
                    char_idx <= '0;
                  end
                  ST_CHARS: begin
                    if (char_idx == IDX_W'(MAX_CHARS - 1)) begin
                      state <= ST_GAP;
                    end else begin
                      char_idx <= char_idx + 1'b1;
                    end
                  end
                  default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                  end
                endcase
              end
              default: step <= TX_LOAD;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_team_06_lcd_sequencer.sv
// Directed bench for team_06_lcd_sequencer: acking I2C master model plus an expected-transaction queue.
module tb_team_06_lcd_sequencer;
  import team_06_lcd_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic [2:0] msg_sel;
  logic       i2c_idle, i2c_ready, i2c_err;
  logic       i2c_start, i2c_last, busy, shown_valid, lcd_fault;
  logic [7:0] i2c_byte;
  logic [2:0] shown_msg;
  lcd_state_t dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          abort_cnt;
  logic        err_all, err_char_b1;
  logic [31:0] t;

  team_06_lcd_sequencer #(
    .MAX_CHARS  (16),
    .NUM_MSGS   (8),
    .MSG_W      (3),
    .PWRUP_WAIT (10),
    .CMD_GAP    (5),
    .MAX_RETRY  (3)
`ifdef LCD_BACKLIGHT_TIMEOUT_EN
    , .BL_TIMEOUT (50)
`endif
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .msg_sel     (msg_sel),
    .i2c_idle    (i2c_idle),
    .i2c_ready   (i2c_ready),
    .i2c_err     (i2c_err),
    .i2c_start   (i2c_start),
    .i2c_byte    (i2c_byte),
    .i2c_last    (i2c_last),
    .busy        (busy),
    .shown_msg   (shown_msg),
    .shown_valid (shown_valid),
    .lcd_fault   (lcd_fault),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected 4-byte frame for one LCD byte: {hi,BL,E=1,RW=0,RS} {hi,..E=0..} {lo,..E=1..} {lo,..E=0..}
  function automatic logic [31:0] enc(input logic [7:0] b, input logic rs, input logic bl);
    logic [3:0] f1, f0;
    f1 = {bl, 1'b1, 1'b0, rs};
    f0 = {bl, 1'b0, 1'b0, rs};
    return {b[7:4], f1, b[7:4], f0, b[3:0], f1, b[3:0], f0};
  endfunction

  task automatic expect_cmd(input logic [7:0] b);
    exp_q.push_back(enc(b, 1'b0, 1'b1));
  endtask

  task automatic expect_init();
    expect_cmd(8'h33); expect_cmd(8'h32); expect_cmd(8'h28);
    expect_cmd(8'h0C); expect_cmd(8'h06);
  endtask

  task automatic expect_redraw(input string s);
    expect_cmd(8'h01);
    expect_cmd(8'h80);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(enc(s[i], 1'b1, 1'b1));
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, i2c_start, 1'b0);
    chk({tag, "_byte"}, i2c_byte, 8'h08);
    chk({tag, "_last"}, i2c_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_shown_msg"}, shown_msg, 3'd0);
    chk({tag, "_shown_valid"}, shown_valid, 1'b0);
    chk({tag, "_fault"}, lcd_fault, 1'b0);
    chk({tag, "_state"}, dbg_state, ST_PWRUP);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while (!(busy === 1'b0 && shown_valid === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settle"}, busy, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_state(input lcd_state_t st, input string tag);
    int n = 0;
    while (dbg_state !== st && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dbg_state, st);
  endtask

  // I2C master model: acks each byte 3 cycles after it is presented, with optional NACK injection.
  initial begin : bfm
    logic [7:0] got [4];
    logic [3:0] lastv;
    logic       aborted;
    i2c_idle  = 1'b1;
    i2c_ready = 1'b0;
    i2c_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst && i2c_start) begin
        i2c_idle = 1'b0;
        aborted  = 1'b0;
        lastv    = 4'b0000;
        for (int k = 0; k < 4; k++) begin
          repeat (3) @(negedge clk);
          if (!nrst) begin
            aborted = 1'b1;
            break;
          end
          got[k]   = i2c_byte;
          lastv[k] = i2c_last;
          if (err_all || (err_char_b1 && k == 1 && got[0][0])) begin
            err_char_b1 = 1'b0;
            i2c_err = 1'b1;
            @(negedge clk);
            i2c_err = 1'b0;
            aborted = 1'b1;
            abort_cnt++;
            break;
          end
          i2c_ready = 1'b1;
          @(negedge clk);
          i2c_ready = 1'b0;
        end
        i2c_idle = 1'b1;
        if (!aborted) begin
          obs_q.push_back({got[0], got[1], got[2], got[3]});
          chk("i2c_last_pattern", lastv, 4'b1000);
        end
      end
    end
  end

  initial begin : main
    nrst        = 1'b0;
    msg_sel     = 3'd1;
    err_all     = 1'b0;
    err_char_b1 = 1'b0;
    abort_cnt   = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    nrst = 1'b1;

    // power-up, init, first draw of "ECHO"
    expect_init();
    expect_redraw("ECHO");
    wait_quiet("t1");
    t = (obs_q.size() > 7) ? obs_q[7] : 32'h0;
    chk("t1_char_E", t, 32'h4D495D59);
    chk("t1_shown_msg", shown_msg, 3'd1);
    chk("t1_shown_valid", shown_valid, 1'b1);
    chk("t1_busy", busy, 1'b0);
    drain("t1");

    // redraw on msg_sel change
    msg_sel = 3'd3;
    expect_redraw("READY");
    wait_quiet("t2");
    t = (obs_q.size() > 0) ? obs_q[0] : 32'h0;
    chk("t2_clear_frame", t, 32'h0C081C18);
    chk("t2_shown_msg", shown_msg, 3'd3);
    drain("t2");

    // msg_sel wobble during CHARS is ignored
    msg_sel = 3'd0;
    expect_redraw("HELLO");
    wait_quiet("t3a");
    drain("t3a");
    msg_sel = 3'd3;
    wait_state(ST_CHARS, "t3_in_chars");
    msg_sel = 3'd4;
    repeat (8) @(negedge clk);
    msg_sel = 3'd3;
    expect_redraw("READY");
    wait_quiet("t3b");
    chk("t3_shown_msg", shown_msg, 3'd3);
    drain("t3b");

    // NACK on 2nd byte of a character -> re-init and complete
    err_char_b1 = 1'b1;
    msg_sel = 3'd6;
    expect_cmd(8'h01);
    expect_cmd(8'h80);
    expect_init();
    expect_redraw("LCD");
    wait_state(ST_RETRY_WAIT, "t4_retry");
    chk("t4_valid_dropped", shown_valid, 1'b0);
    chk("t4_busy", busy, 1'b1);
    wait_quiet("t4");
    chk("t4_shown_msg", shown_msg, 3'd6);
    chk("t4_shown_valid", shown_valid, 1'b1);
    drain("t4");

    // persistent NACK -> fault after 4 aborts, cleared by msg_sel change
    abort_cnt = 0;
    err_all = 1'b1;
    msg_sel = 3'd2;
    wait_state(ST_FAULT, "t5_fault_state");
    chk("t5_aborts", abort_cnt, 4);
    chk("t5_fault", lcd_fault, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", shown_valid, 1'b0);
    err_all = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_fault_sticky", lcd_fault, 1'b1);
    drain("t5_none");
    msg_sel = 3'd7;
    repeat (2) @(negedge clk);
    chk("t5_fault_clear", lcd_fault, 1'b0);
    chk("t5_reinit", dbg_state, ST_INIT);
    expect_init();
    expect_redraw("BYE");
    wait_quiet("t5");
    chk("t5_shown_msg", shown_msg, 3'd7);
    drain("t5");

    // async reset mid-CHARS, then full restart of a 16-character message
    msg_sel = 3'd5;
    wait_state(ST_CHARS, "t6_in_chars");
    repeat (45) @(negedge clk);
    nrst = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    repeat (8) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    nrst = 1'b1;
    expect_init();
    expect_redraw("0123456789ABCDEF");
    wait_quiet("t6");
    chk("t6_shown_msg", shown_msg, 3'd5);
    chk("t6_shown_valid", shown_valid, 1'b1);
    drain("t6");
`ifdef LCD_BACKLIGHT_TIMEOUT_EN
    repeat (70) @(negedge clk);
    exp_q.push_back(32'h00000000);
    drain("t6_bl_off");
    chk("t6_bl_idle", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
